efx_ed_axi_achan_split: RTL and testbench
=========================================

Name: efx_ed_axi_achan_split

Overview:
- Sits directly downstream of the HyperRAM AXI traffic generator/checker and upstream of the controller's AXI4 slave port.
- Takes the generator's unified address channel: a* fields, with atype 1 = write and 0 = read.
- Registers each command in a one-entry holding stage and steers it onto a standard AXI4 AW or AR channel.
- Enforces read-after-write ordering and outstanding-transaction limits, and terminates the B channel on the generator's behalf, since the generator holds bready low.

Parameters:
ADDR_W, 32, address width
ID_W, 8, transaction ID width
MAX_OUTSTANDING, 4, max AW accepted without matching B; also max AR accepted without final rlast (1..15)
ORDER_RAW, 1, 1 = block AR issue while any write is outstanding; 0 = no ordering

Ports:
axi_clk  in  1  single clock, all logic rising-edge
rstn  in  1  asynchronous active-low reset
s_aid  in  ID_W  command ID
s_aaddr  in  ADDR_W  command address
s_alen  in  8  burst length-1
s_asize  in  3  beat size
s_aburst  in  2  burst type
s_alock  in  2  lock
s_atype  in  1  1 = write, 0 = read
s_avalid  in  1  command valid
s_aready  out  1  command accepted
m_aw{id,addr,len,size,burst,lock}  out  as s_a*  write address fields
m_awvalid  out  1  write address valid
m_awready  in  1  slave accepts AW
m_ar{id,addr,len,size,burst,lock}  out  as s_a*  read address fields
m_arvalid  out  1  read address valid
m_arready  in  1  slave accepts AR
m_bid  in  ID_W  write response ID (unused except for debug)
m_bresp  in  2  write response
m_bvalid  in  1  write response valid
m_bready  out  1  always 1 after reset
m_rvalid  in  1  read beat observed (monitor only)
m_rready  in  1  read ready as driven by generator (monitor only)
m_rlast  in  1  last read beat
wr_outstanding  out  4  current outstanding-write count
rd_outstanding  out  4  current outstanding-read count
bresp_err  out  1  sticky: any B with bresp != OKAY
b_underflow  out  1  sticky: B received while wr_outstanding = 0

Behaviour:
- Reset values: all m_* valids 0, address fields 0, m_bready 0, s_aready 0, both counters 0, both sticky flags 0.
- m_bready goes 1 on the first clock after reset release and stays 1.
- Holding register: one entry with a full flag.
  - s_aready = ~full | issue_fire, where issue_fire = (m_awvalid & m_awready) | (m_arvalid & m_arready).
  - This is registered-input combinational ready, so back-to-back commands sustain 1 per cycle when the slave is always ready.
- Load: on s_avalid & s_aready, capture all fields and type; full = 1.
  - Capture and issue_fire in the same cycle gives full = 1 with the new command.
- Issue (combinational from the held entry; fields on both AW and AR equal the held fields):
  - m_awvalid = full & type & (wr_outstanding < MAX_OUTSTANDING).
  - m_arvalid = full & ~type & (rd_outstanding < MAX_OUTSTANDING) & ~(ORDER_RAW & wr_outstanding != 0).
  - Once m_*valid is asserted it must not deassert before ready. This is guaranteed because counters only decrement while the entry is held.
- Latency: s_a handshake to m_awvalid/m_arvalid is 1 cycle minimum.
- wr_outstanding:
  - +1 on AW fire; -1 on m_bvalid (m_bready = 1).
  - Both in the same cycle leaves it unchanged.
  - B at count 0 leaves it at 0 and sets b_underflow.
- rd_outstanding:
  - +1 on AR fire; -1 on m_rvalid & m_rready & m_rlast.
  - Both in the same cycle leaves it unchanged.
  - Decrement at 0 saturates at 0, with no flag.
- bresp_err sets on m_bvalid & (m_bresp != 2'b00). Both sticky flags clear only on reset.
- Reset asserted mid-burst: all state clears immediately; the upstream command in flight is dropped.
- No combinational path from s_avalid to any m_* output.

Decomposition:
- Shared package efx_ed_axi_pkg: command struct (id, addr, len, size, burst, lock, type), AXI_RESP_OKAY constant, ATYPE_WR/ATYPE_RD constants.
- Sub-module efx_ed_sat_cnt: up/down saturating counter with underflow pulse, parameterized width/max. Instantiated twice.

Test Plan:
1. Single write: s_atype = 1, addr 0x0000_0000, len 127, size 4. Required: m_awvalid next cycle with identical fields; wr_outstanding = 1 after fire; m_bvalid pulse returns it to 0.
2. RAW ordering, ORDER_RAW = 1: write accepted, B withheld, then read to 0x800 queued. Required: m_arvalid stays 0 and s_aready stays 0 until the B cycle; m_arvalid rises the next cycle.
3. Outstanding limit: 5 writes with m_awready = 1, no B. Required: 4 AW fires, wr_outstanding = 4, 5th held with m_awvalid = 0; one B lets it issue the next cycle.
4. Streaming: 8 reads with m_arready = 1 and rlast returned each 2 cycles, MAX = 4. Required: 1 command/cycle until rd_outstanding = 4, then throughput matches rlast rate; all ARs in order.
5. Simultaneous events: AW fire and m_bvalid in the same cycle at count 2 leaves the count at 2. Stray B at count 0 sets b_underflow = 1 and the count stays 0. bresp = 2'b10 sets bresp_err.
6. Reset mid-operation: rstn low while full and rd_outstanding = 3. Required: all valids 0, counters 0 and flags 0 asynchronously; m_bready 0 until the first clock after release.

Source files
------------

// File: rtl/efx_ed_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : efx_ed_axi_pkg
// Description : Shared types and constants for the HyperRAM AXI address-channel
//               splitter. Holds the per-command attribute struct and the AXI
//               response and command-type encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package efx_ed_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Encoding of the generator's unified-channel s_atype field
  localparam logic ATYPE_WR = 1'b1;
  localparam logic ATYPE_RD = 1'b0;

  // Outstanding counters are 4 bits, enough for a limit of 1..15
  localparam int CNT_W = 4;

  // Width-independent command attributes. The parameterised id and address
  // are held alongside this struct in the splitter.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [1:0] lock;
    logic       typ;
  } cmd_attr_t;

endpackage
`default_nettype wire

// File: rtl/efx_ed_axi_achan_split_if.sv
`default_nettype none
// ============================================================================
// Module      : efx_ed_axi_achan_split_if
// Description : Bus bundle around the address-channel splitter: the unified
//               command channel from the traffic generator, the AXI4 AW/AR
//               channels to the controller, the B channel the splitter
//               terminates, and the R handshake it only monitors.
// Modports    : slave  - the splitter itself
//               master - the surrounding environment (generator + controller)
// Revision    : 1.0 - initial release
// ============================================================================
interface efx_ed_axi_achan_split_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 8
) ();

  // Unified command channel
  logic [ID_W-1:0]   s_aid;
  logic [ADDR_W-1:0] s_aaddr;
  logic [7:0]        s_alen;
  logic [2:0]        s_asize;
  logic [1:0]        s_aburst;
  logic [1:0]        s_alock;
  logic              s_atype;
  logic              s_avalid;
  logic              s_aready;

  // AXI4 write address
  logic [ID_W-1:0]   m_awid;
  logic [ADDR_W-1:0] m_awaddr;
  logic [7:0]        m_awlen;
  logic [2:0]        m_awsize;
  logic [1:0]        m_awburst;
  logic [1:0]        m_awlock;
  logic              m_awvalid;
  logic              m_awready;

  // AXI4 read address
  logic [ID_W-1:0]   m_arid;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic [1:0]        m_arlock;
  logic              m_arvalid;
  logic              m_arready;

  // Write response (terminated here) and read-data monitor
  logic [ID_W-1:0]   m_bid;
  logic [1:0]        m_bresp;
  logic              m_bvalid;
  logic              m_bready;
  logic              m_rvalid;
  logic              m_rready;
  logic              m_rlast;

  modport slave (
    input  s_aid, s_aaddr, s_alen, s_asize, s_aburst, s_alock, s_atype, s_avalid,
    output s_aready,
    output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awvalid,
    input  m_awready,
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arvalid,
    input  m_arready,
    input  m_bid, m_bresp, m_bvalid,
    output m_bready,
    input  m_rvalid, m_rready, m_rlast
  );

  modport master (
    output s_aid, s_aaddr, s_alen, s_asize, s_aburst, s_alock, s_atype, s_avalid,
    input  s_aready,
    input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awvalid,
    output m_awready,
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arvalid,
    output m_arready,
    output m_bid, m_bresp, m_bvalid,
    input  m_bready,
    output m_rvalid, m_rready, m_rlast
  );

endinterface
`default_nettype wire

// File: rtl/efx_ed_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : efx_ed_sat_cnt
// Description : Up/down counter saturating at 0 and MAX. Simultaneous inc and
//               dec hold the count. underflow pulses (combinationally) when a
//               lone dec arrives with the count already at 0.
// Ports       : clk, rst_n (async active-low), inc, dec, count, underflow
// Revision    : 1.0 - initial release
// ============================================================================
module efx_ed_sat_cnt #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({inc, dec})
        2'b10:   if (r_count != c_max) r_count <= r_count + 1'b1;
        2'b01:   if (r_count != '0)    r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign count     = r_count;
  assign underflow = dec & ~inc & (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/efx_ed_axi_achan_split.sv
`default_nettype none
// ============================================================================
// Module      : efx_ed_axi_achan_split
// Description : Registers each unified-channel command in a one-entry holding
//               stage and steers it to AXI4 AW (write) or AR (read). Limits
//               outstanding writes/reads, optionally blocks reads while writes
//               are outstanding, and sinks the B channel for the generator.
// Ports       : axi_clk, rstn (async active-low)
//               bus            - command / AW / AR / B / R bundle (slave view)
//               wr_outstanding - AWs issued without a B
//               rd_outstanding - ARs issued without a final rlast
//               bresp_err      - sticky: a B with non-OKAY response was seen
//               b_underflow    - sticky: a B arrived with no write outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module efx_ed_axi_achan_split
  import efx_ed_axi_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int ID_W            = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ORDER_RAW       = 1
) (
  input  logic                  axi_clk,
  input  logic                  rstn,
  efx_ed_axi_achan_split_if.slave bus,
  output logic [CNT_W-1:0]      wr_outstanding,
  output logic [CNT_W-1:0]      rd_outstanding,
  output logic                  bresp_err,
  output logic                  b_underflow
);

  localparam logic [CNT_W-1:0] c_max       = CNT_W'(MAX_OUTSTANDING);
  localparam logic             c_order_raw = (ORDER_RAW != 0);

  // Holding stage
  logic              r_full;
  logic [ID_W-1:0]   r_id;
  logic [ADDR_W-1:0] r_addr;
  cmd_attr_t         r_attr;

  // Goes high on the first clock after reset release; drives m_bready and
  // keeps s_aready low while in reset.
  logic r_active;

  logic r_bresp_err;
  logic r_b_underflow;

  logic w_aw_valid;
  logic w_ar_valid;
  logic w_aw_fire;
  logic w_ar_fire;
  logic w_issue_fire;
  logic w_s_aready;
  logic w_load;
  logic w_b_take;
  logic w_r_done;
  logic w_wr_uflow;

  // Issue decode. Counters only fall while an entry is held, so once a valid
  // is raised it cannot be withdrawn before its ready.
  assign w_aw_valid = r_full & (r_attr.typ == ATYPE_WR) & (wr_outstanding < c_max);
  assign w_ar_valid = r_full & (r_attr.typ == ATYPE_RD) & (rd_outstanding < c_max)
                    & ~(c_order_raw & (wr_outstanding != '0));

  assign w_aw_fire    = w_aw_valid & bus.m_awready;
  assign w_ar_fire    = w_ar_valid & bus.m_arready;
  assign w_issue_fire = w_aw_fire | w_ar_fire;

  // Ready depends only on registered state and downstream ready, so there is
  // no path from s_avalid to any m_* output.
  assign w_s_aready = r_active & (~r_full | w_issue_fire);
  assign w_load     = bus.s_avalid & w_s_aready;

  assign w_b_take = bus.m_bvalid & r_active;
  assign w_r_done = bus.m_rvalid & bus.m_rready & bus.m_rlast;

  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) begin
      r_active <= 1'b0;
      r_full   <= 1'b0;
      r_id     <= '0;
      r_addr   <= '0;
      r_attr   <= '0;
    end else begin
      r_active <= 1'b1;
      if (w_load) begin
        r_full       <= 1'b1;
        r_id         <= bus.s_aid;
        r_addr       <= bus.s_aaddr;
        r_attr.len   <= bus.s_alen;
        r_attr.size  <= bus.s_asize;
        r_attr.burst <= bus.s_aburst;
        r_attr.lock  <= bus.s_alock;
        r_attr.typ   <= bus.s_atype;
      end else if (w_issue_fire) begin
        r_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge axi_clk or negedge rstn) begin
    if (!rstn) begin
      r_bresp_err   <= 1'b0;
      r_b_underflow <= 1'b0;
    end else begin
      if (w_b_take && (bus.m_bresp != AXI_RESP_OKAY)) r_bresp_err <= 1'b1;
      if (w_wr_uflow) r_b_underflow <= 1'b1;
    end
  end

  efx_ed_sat_cnt #(.WIDTH(CNT_W), .MAX(MAX_OUTSTANDING)) u_wr_cnt (
    .clk       (axi_clk),
    .rst_n     (rstn),
    .inc       (w_aw_fire),
    .dec       (w_b_take),
    .count     (wr_outstanding),
    .underflow (w_wr_uflow)
  );

  // A stray final beat at count 0 is silently absorbed.
  efx_ed_sat_cnt #(.WIDTH(CNT_W), .MAX(MAX_OUTSTANDING)) u_rd_cnt (
    .clk       (axi_clk),
    .rst_n     (rstn),
    .inc       (w_ar_fire),
    .dec       (w_r_done),
    .count     (rd_outstanding),
    .underflow ()
  );

  assign bus.s_aready  = w_s_aready;
  assign bus.m_bready  = r_active;

  assign bus.m_awid    = r_id;
  assign bus.m_awaddr  = r_addr;
  assign bus.m_awlen   = r_attr.len;
  assign bus.m_awsize  = r_attr.size;
  assign bus.m_awburst = r_attr.burst;
  assign bus.m_awlock  = r_attr.lock;
  assign bus.m_awvalid = w_aw_valid;

  assign bus.m_arid    = r_id;
  assign bus.m_araddr  = r_addr;
  assign bus.m_arlen   = r_attr.len;
  assign bus.m_arsize  = r_attr.size;
  assign bus.m_arburst = r_attr.burst;
  assign bus.m_arlock  = r_attr.lock;
  assign bus.m_arvalid = w_ar_valid;

  assign bresp_err   = r_bresp_err;
  assign b_underflow = r_b_underflow;

endmodule
`default_nettype wire

// File: tb/tb_efx_ed_axi_achan_split.sv
`default_nettype none
// ============================================================================
// Module      : tb_efx_ed_axi_achan_split
// Description : Directed bench for the address-channel splitter. Commands are
//               pushed to per-channel expectation queues on acceptance and
//               popped when AW/AR fires; counters and flags are checked at
//               fixed points of the directed sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_efx_ed_axi_achan_split;

  localparam int ADDR_W = 32;
  localparam int ID_W   = 8;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  lock;
  } cmd_s;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] wr_outstanding;
  logic [3:0] rd_outstanding;
  logic       bresp_err;
  logic       b_underflow;

  efx_ed_axi_achan_split_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

  efx_ed_axi_achan_split #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .MAX_OUTSTANDING(4), .ORDER_RAW(1)
  ) dut (
    .axi_clk        (clk),
    .rstn           (rstn),
    .bus            (bus.slave),
    .wr_outstanding (wr_outstanding),
    .rd_outstanding (rd_outstanding),
    .bresp_err      (bresp_err),
    .b_underflow    (b_underflow)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   aw_fires = 0;
  int   ar_fires = 0;
  int   rl_done = 0;
  int   rd_peak = 0;
  cmd_s exp_aw[$];
  cmd_s exp_ar[$];
  int   ar_cyc[$];
  cmd_s mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(input cmd_s c);
    return {9'd0, c.id, c.addr, c.len, c.size, c.burst, c.lock};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Holds s_avalid until accepted; returns just after the accepting edge with
  // s_avalid still high so commands can be streamed back to back.
  task automatic push_cmd(input logic [7:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic typ);
    cmd_s c;
    int   t;
    c.id = id; c.addr = addr; c.len = len; c.size = size;
    c.burst = id[1:0]; c.lock = id[3:2];
    bus.s_aid = c.id; bus.s_aaddr = c.addr; bus.s_alen = c.len; bus.s_asize = c.size;
    bus.s_aburst = c.burst; bus.s_alock = c.lock; bus.s_atype = typ; bus.s_avalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (bus.s_aready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("s_accept", 64'(bus.s_aready), 64'(1));
    if (typ) exp_aw.push_back(c); else exp_ar.push_back(c);
    tick();
  endtask

  task automatic idle_a();
    bus.s_avalid = 1'b0;
  endtask

  task automatic pulse_b(input logic [1:0] resp);
    bus.m_bvalid = 1'b1; bus.m_bresp = resp; bus.m_bid = 8'h5A;
    tick();
    bus.m_bvalid = 1'b0; bus.m_bresp = 2'b00;
  endtask

  task automatic pulse_rlast();
    bus.m_rvalid = 1'b1; bus.m_rready = 1'b1; bus.m_rlast = 1'b1;
    tick();
    bus.m_rvalid = 1'b0; bus.m_rready = 1'b0; bus.m_rlast = 1'b0;
  endtask

  // Scoreboard side: every AW/AR fire must match the oldest accepted command
  // of that type; the outstanding limit must hold off further issue.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (bus.m_awvalid === 1'b1 && bus.m_awready === 1'b1) begin
        chk("aw_expected", 64'(exp_aw.size() != 0), 64'(1));
        if (exp_aw.size() != 0) begin
          mon_e = exp_aw.pop_front();
          chk("aw_fields", pk('{bus.m_awid, bus.m_awaddr, bus.m_awlen, bus.m_awsize,
                                bus.m_awburst, bus.m_awlock}), pk(mon_e));
        end
        aw_fires++;
      end
      if (bus.m_arvalid === 1'b1 && bus.m_arready === 1'b1) begin
        chk("ar_expected", 64'(exp_ar.size() != 0), 64'(1));
        if (exp_ar.size() != 0) begin
          mon_e = exp_ar.pop_front();
          chk("ar_fields", pk('{bus.m_arid, bus.m_araddr, bus.m_arlen, bus.m_arsize,
                                bus.m_arburst, bus.m_arlock}), pk(mon_e));
        end
        ar_fires++;
        ar_cyc.push_back(cyc);
      end
      if (int'(rd_outstanding) > rd_peak) rd_peak = int'(rd_outstanding);
      if (wr_outstanding == 4'd4) chk("aw_limit", 64'(bus.m_awvalid), 64'(0));
      if (rd_outstanding == 4'd4) chk("ar_limit", 64'(bus.m_arvalid), 64'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus.s_aid = '0; bus.s_aaddr = '0; bus.s_alen = '0; bus.s_asize = '0;
    bus.s_aburst = '0; bus.s_alock = '0; bus.s_atype = 1'b0; bus.s_avalid = 1'b0;
    bus.m_awready = 1'b0; bus.m_arready = 1'b0;
    bus.m_bid = '0; bus.m_bresp = '0; bus.m_bvalid = 1'b0;
    bus.m_rvalid = 1'b0; bus.m_rready = 1'b0; bus.m_rlast = 1'b0;

    // ---- Reset state ----
    #12;
    chk("rst_awvalid", 64'(bus.m_awvalid), 64'(0));
    chk("rst_arvalid", 64'(bus.m_arvalid), 64'(0));
    chk("rst_bready",  64'(bus.m_bready),  64'(0));
    chk("rst_saready", 64'(bus.s_aready),  64'(0));
    chk("rst_awaddr",  64'(bus.m_awaddr),  64'(0));
    chk("rst_counts",  64'({wr_outstanding, rd_outstanding}), 64'(0));
    chk("rst_flags",   64'({bresp_err, b_underflow}), 64'(0));
    @(posedge clk); #2; rstn = 1'b1;
    #1 chk("rel_bready_low", 64'(bus.m_bready), 64'(0));
    tick();
    chk("rel_bready_high", 64'(bus.m_bready), 64'(1));
    chk("rel_saready",     64'(bus.s_aready), 64'(1));

    // ---- 1: single write ----
    bus.m_awready = 1'b1; bus.m_arready = 1'b1;
    push_cmd(8'h11, 32'h0000_0000, 8'd127, 3'd4, 1'b1);
    idle_a();
    sample();
    chk("t1_awvalid", 64'(bus.m_awvalid), 64'(1));
    chk("t1_awlen",   64'(bus.m_awlen),   64'(127));
    chk("t1_awsize",  64'(bus.m_awsize),  64'(4));
    chk("t1_arvalid", 64'(bus.m_arvalid), 64'(0));
    tick(); sample();
    chk("t1_wr_after_fire", 64'(wr_outstanding), 64'(1));
    tick();
    pulse_b(2'b00);
    sample();
    chk("t1_wr_after_b", 64'(wr_outstanding), 64'(0));
    chk("t1_bresp_err",  64'(bresp_err),      64'(0));

    // ---- 2: read-after-write ordering ----
    tick();
    push_cmd(8'h21, 32'h0000_0400, 8'd15, 3'd4, 1'b1);
    push_cmd(8'h22, 32'h0000_0800, 8'd15, 3'd4, 1'b0);
    idle_a();
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("t2_ar_blocked",  64'(bus.m_arvalid), 64'(0));
      chk("t2_s_blocked",   64'(bus.s_aready),  64'(0));
      tick();
    end
    bus.m_bvalid = 1'b1;
    sample();
    chk("t2_ar_b_cycle", 64'(bus.m_arvalid), 64'(0));
    tick();
    bus.m_bvalid = 1'b0;
    sample();
    chk("t2_ar_after_b", 64'(bus.m_arvalid), 64'(1));
    chk("t2_araddr",     64'(bus.m_araddr),  64'(32'h800));
    tick();
    pulse_rlast();
    sample();
    chk("t2_counts", 64'({wr_outstanding, rd_outstanding}), 64'(0));

    // ---- 3: outstanding write limit ----
    tick();
    for (int i = 0; i < 5; i++) push_cmd(8'h30 + 8'(i), 32'h2000 + 32'(i) * 32'h80, 8'd7, 3'd3, 1'b1);
    idle_a();
    sample();
    chk("t3_wr_full",   64'(wr_outstanding), 64'(4));
    chk("t3_aw_held",   64'(bus.m_awvalid),  64'(0));
    chk("t3_one_left",  64'(exp_aw.size()),  64'(1));
    tick(); tick(); sample();
    chk("t3_aw_still_held", 64'(bus.m_awvalid), 64'(0));
    tick();
    pulse_b(2'b00);
    sample();
    chk("t3_aw_released", 64'(bus.m_awvalid), 64'(1));
    chk("t3_wr_dec",      64'(wr_outstanding), 64'(3));
    tick(); sample();
    chk("t3_wr_refill",   64'(wr_outstanding), 64'(4));
    chk("t3_aw_drained",  64'(exp_aw.size()),  64'(0));
    tick();
    repeat (4) pulse_b(2'b00);
    sample();
    chk("t3_wr_zero", 64'(wr_outstanding), 64'(0));

    // ---- 4: read streaming with rlast every other cycle ----
    tick();
    ar_cyc.delete();
    ar_fires = 0; rl_done = 0; rd_peak = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          push_cmd(8'h40 + 8'(i), 32'h1000 + 32'(i) * 32'h100, 8'd3, 3'd2, 1'b0);
        idle_a();
      end
      begin
        int  t;
        bit  ph;
        t = 0; ph = 1'b0;
        while (rl_done < 8 && t < 400) begin
          if (ph && (ar_fires - rl_done) > 0) begin
            bus.m_rvalid = 1'b1; bus.m_rready = 1'b1; bus.m_rlast = 1'b1;
            rl_done++;
          end else begin
            bus.m_rvalid = 1'b0; bus.m_rready = 1'b0; bus.m_rlast = 1'b0;
          end
          ph = ~ph;
          tick();
          t++;
        end
        bus.m_rvalid = 1'b0; bus.m_rready = 1'b0; bus.m_rlast = 1'b0;
      end
    join
    sample();
    chk("t4_ar_count", 64'(ar_cyc.size()), 64'(8));
    if (ar_cyc.size() >= 4) begin
      for (int i = 1; i < 4; i++) chk("t4_ar_b2b", 64'(ar_cyc[i] - ar_cyc[i-1]), 64'(1));
    end
    chk("t4_rd_peak",  64'(rd_peak),        64'(4));
    chk("t4_rd_zero",  64'(rd_outstanding), 64'(0));
    chk("t4_ar_empty", 64'(exp_ar.size()),  64'(0));

    // ---- 5: simultaneous events, stray B, error response ----
    tick();
    push_cmd(8'h51, 32'h3000, 8'd1, 3'd2, 1'b1);
    push_cmd(8'h52, 32'h3100, 8'd1, 3'd2, 1'b1);
    idle_a();
    tick(); sample();
    chk("t5_wr_two", 64'(wr_outstanding), 64'(2));
    tick();
    bus.m_awready = 1'b0;
    push_cmd(8'h53, 32'h3200, 8'd1, 3'd2, 1'b1);
    idle_a();
    sample();
    chk("t5_aw_pending", 64'(bus.m_awvalid), 64'(1));
    tick();
    bus.m_awready = 1'b1;
    pulse_b(2'b00);
    sample();
    chk("t5_wr_simul", 64'(wr_outstanding), 64'(2));
    chk("t5_no_uflow", 64'(b_underflow),    64'(0));
    tick();
    repeat (2) pulse_b(2'b00);
    pulse_b(2'b00);
    sample();
    chk("t5_wr_stays_zero", 64'(wr_outstanding), 64'(0));
    chk("t5_b_underflow",   64'(b_underflow),    64'(1));
    chk("t5_no_bresp_err",  64'(bresp_err),      64'(0));
    tick();
    pulse_b(2'b10);
    sample();
    chk("t5_bresp_err",  64'(bresp_err),       64'(1));
    chk("t5_queues_empty", 64'(exp_aw.size() + exp_ar.size()), 64'(0));

    // ---- 6: reset mid-operation ----
    tick();
    for (int i = 0; i < 3; i++) push_cmd(8'h60 + 8'(i), 32'h4000 + 32'(i) * 32'h40, 8'd0, 3'd2, 1'b0);
    idle_a();
    tick();
    bus.m_arready = 1'b0;
    push_cmd(8'h63, 32'h40C0, 8'd0, 3'd2, 1'b0);
    idle_a();
    sample();
    chk("t6_rd_three", 64'(rd_outstanding), 64'(3));
    chk("t6_ar_held",  64'(bus.m_arvalid),  64'(1));
    exp_ar.delete();
    #1 rstn = 1'b0;
    #1;
    chk("t6_arvalid", 64'(bus.m_arvalid), 64'(0));
    chk("t6_awvalid", 64'(bus.m_awvalid), 64'(0));
    chk("t6_counts",  64'({wr_outstanding, rd_outstanding}), 64'(0));
    chk("t6_flags",   64'({bresp_err, b_underflow}), 64'(0));
    chk("t6_bready",  64'(bus.m_bready),  64'(0));
    chk("t6_saready", 64'(bus.s_aready),  64'(0));
    chk("t6_araddr",  64'(bus.m_araddr),  64'(0));
    @(posedge clk); #2; rstn = 1'b1;
    #1 chk("t6_rel_bready_low", 64'(bus.m_bready), 64'(0));
    tick();
    chk("t6_rel_bready_high", 64'(bus.m_bready), 64'(1));
    chk("t6_rel_arvalid",     64'(bus.m_arvalid), 64'(0));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
